// File: rtl/oled_pkg.sv
// Shared OLED definitions: SPI FSM states, D/C# encodings and SCLK divider helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package oled_pkg;

  // Byte-transmitter states, also visible to the OLED controller
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    GAP      = 3'd4
  } oled_state_t;

  // D/C# pin encodings
  localparam logic OLED_CMD = 1'b0;
  localparam logic OLED_DAT = 1'b1;

  // clk cycles per SCLK half-period, never below one
  function automatic int half_div_calc(input int clk_fre, input int spi_fre);
    int d;
    d = clk_fre / (2 * spi_fre);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/oled_spi_tx.sv
// Serialises one byte MSB-first to an SPI OLED panel (CPOL=0) with chip select and D/C#.
// Latency: busy rises the cycle after accept and lasts 18*HALF_DIV cycles (setup, 8 bits, CS hold, gap).
// Backpressure: send_en is only taken while send_busy=0; requests during busy are ignored.
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int CLK_FRE = 50,
  parameter int SPI_FRE = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_en,
  input  logic       send_dc,
  input  logic [7:0] send_data,
  output logic       send_busy,
  output logic       oled_sclk,
  output logic       oled_mosi,
  output logic       oled_cs_n,
  output logic       oled_dc
);

  localparam int HALF_DIV = half_div_calc(CLK_FRE, SPI_FRE);
  // counter width kept at least one bit so HALF_DIV=1 still elaborates
  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] HALF_ONE  = CW'(1);

  oled_state_t   state_q, state_d;
  logic [CW-1:0] half_q, half_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          half_last;

  // next values of the registered pins, derived from the next state
  logic          busy_d, sclk_d, mosi_d, cs_n_d, dc_d;

  assign half_last = (half_q == HALF_LAST);

  // State, divider, bit counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state sequencing and next pin values
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dc_d    = oled_dc;

    unique case (state_q)
      IDLE: begin
        if (send_en && !send_busy) begin
          state_d = SETUP;
          half_d  = '0;
          bit_d   = '0;
          shreg_d = send_data;
          dc_d    = send_dc;
        end
      end
      SETUP: begin
        if (half_last) begin
          state_d = SHIFT_HI;
          half_d  = '0;
        end else begin
          half_d = half_q + HALF_ONE;
        end
      end
      SHIFT_HI: begin
        if (half_last) begin
          state_d = SHIFT_LO;
          half_d  = '0;
          // next bit moves onto MOSI on the falling SCLK edge
          shreg_d = {shreg_q[6:0], 1'b0};
        end else begin
          half_d = half_q + HALF_ONE;
        end
      end
      SHIFT_LO: begin
        if (half_last) begin
          half_d = '0;
          if (bit_q == 3'd7) begin
            // the low phase after bit 0 doubles as CS hold time
            state_d = GAP;
          end else begin
            state_d = SHIFT_HI;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          half_d = half_q + HALF_ONE;
        end
      end
      GAP: begin
        if (half_last) begin
          state_d = IDLE;
          half_d  = '0;
        end else begin
          half_d = half_q + HALF_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        half_d  = '0;
        bit_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
    sclk_d = (state_d == SHIFT_HI);
    cs_n_d = (state_d == IDLE) || (state_d == GAP);
    mosi_d = cs_n_d ? 1'b0 : shreg_d[7];
  end

  // Pin registers: every output comes straight from a flop, so no glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_busy <= 1'b0;
      oled_sclk <= 1'b0;
      oled_mosi <= 1'b0;
      oled_cs_n <= 1'b1;
      oled_dc   <= 1'b0;
    end else begin
      send_busy <= busy_d;
      oled_sclk <= sclk_d;
      oled_mosi <= mosi_d;
      oled_cs_n <= cs_n_d;
      oled_dc   <= dc_d;
    end
  end

endmodule
